// File: rtl/mfp_uart_rx_16x_pkg.sv
// Shared constants, state encoding and helpers for the 16x oversampling UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mfp_uart_rx_16x_pkg;

   localparam int OVERSAMPLE = 16;

   // Tick numbers within a bit period at which the line is sampled for the majority vote.
   localparam logic [3:0] SAMPLE_A  = 4'd7;
   localparam logic [3:0] SAMPLE_B  = 4'd8;
   localparam logic [3:0] SAMPLE_C  = 4'd9;
   localparam logic [3:0] LAST_TICK = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

   // Clocks per oversample tick, rounded to nearest.
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/mfp_uart_rx_16x_if.sv
// Receiver-to-parser signal bundle: serial line in, received byte and status pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; byte_ready and framing_error are fire-and-forget pulses.
interface mfp_uart_rx_16x_if;
   logic       rx;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       framing_error;
   logic       busy;

   modport master (
      input  rx,
      output byte_data,
      output byte_ready,
      output framing_error,
      output busy
   );

   modport slave (
      output rx,
      input  byte_data,
      input  byte_ready,
      input  framing_error,
      input  busy
   );
endinterface

// File: rtl/mfp_uart_rx_16x_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
// Latency: first tick DIV cycles after clear drops.
// Backpressure: none; clear holds the counter at zero and suppresses tick.
module mfp_uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);
   localparam int            CW      = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   if (DIV < 2) begin : g_div_chk
      $error("mfp_uart_baud_tick: DIV must be at least 2");
   end

   logic [CW-1:0] cnt;

   // Free-running divider, restarted by clear so ticks phase-align to the start edge.
   always_ff @(posedge clock) begin
      if (!reset_n || clear || cnt == CNT_MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == CNT_MAX) && !clear;

endmodule

// File: rtl/mfp_uart_rx_16x.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
// Latency: byte_ready rises SYNC_STAGES+1 cycles after rx reaches mid-stop-bit sample tick 9.
// Backpressure: none; each valid byte is a single-cycle pulse, framing errors never forward data.
module mfp_uart_rx_16x
   import mfp_uart_rx_16x_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int BAUD        = 115200,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   mfp_uart_rx_16x_if.master bus
);
   localparam int DIV = calc_div(CLK_HZ, BAUD);

   if (SYNC_STAGES < 2) begin : g_sync_chk
      $error("mfp_uart_rx_16x: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   rx_state_t              state, state_nxt;
   logic                   tick, tick_clr;
   logic [3:0]             tidx, tick_num;
   logic                   at_a, at_b, at_mid, at_end;
   logic                   samp_a, samp_b, maj;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift;
   logic                   load_byte, flag_ferr, busy;
   logic [7:0]             byte_data_q;
   logic                   byte_ready_q, ferr_q;

   // Bring the asynchronous line into the clock domain; idles high out of reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
      end
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

   // Divider is parked while idle, so the cycle that sees the start edge is tick 0.
   assign tick_clr = (state == ST_IDLE);

   mfp_uart_baud_tick #(.DIV(DIV)) u_tick (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (tick_clr),
      .tick    (tick)
   );

   // tick_num is the index of the tick being signalled this cycle (wraps 15->0 into the next bit).
   assign tick_num = tidx + 4'd1;
   assign at_a     = tick && (tick_num == SAMPLE_A);
   assign at_b     = tick && (tick_num == SAMPLE_B);
   assign at_mid   = tick && (tick_num == SAMPLE_C);
   assign at_end   = tick && (tick_num == LAST_TICK);
   assign maj      = majority3(samp_a, samp_b, rx_s);

   // Bit-tick index: position within the current bit period.
   always_ff @(posedge clock) begin
      if (!reset_n || tick_clr) begin
         tidx <= '0;
      end else if (tick) begin
         tidx <= tick_num;
      end
   end

   // Capture the first two votes; the third is the live synchronised line at tick 9.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         if (at_a) samp_a <= rx_s;
         if (at_b) samp_b <= rx_s;
      end
   end

   // Shift data in LSB first at mid-bit and count bits at the end of each bit period.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         shift   <= '0;
         bit_cnt <= '0;
      end else begin
         if (state == ST_DATA && at_mid) shift <= {maj, shift[7:1]};
         if (state == ST_START && at_end) begin
            bit_cnt <= '0;
         end else if (state == ST_DATA && at_end) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state: frame sequencing, false-start rejection and break wait.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!rx_s) state_nxt = ST_START;
         ST_START: begin
            if (at_mid && maj)  state_nxt = ST_IDLE;
            else if (at_end)    state_nxt = ST_DATA;
         end
         ST_DATA:  if (at_end && bit_cnt == 3'd7) state_nxt = ST_STOP;
         ST_STOP:  if (at_mid) state_nxt = maj ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rx_s) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: accept or reject the frame at mid-stop-bit.
   always_comb begin
      busy      = (state != ST_IDLE);
      load_byte = (state == ST_STOP) && at_mid && maj;
      flag_ferr = (state == ST_STOP) && at_mid && !maj;
   end

   // Registered result pulses; byte_data only moves on a good frame.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         byte_data_q  <= '0;
         byte_ready_q <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         byte_ready_q <= load_byte;
         ferr_q       <= flag_ferr;
         if (load_byte) byte_data_q <= shift;
      end
   end

   assign bus.byte_data     = byte_data_q;
   assign bus.byte_ready    = byte_ready_q;
   assign bus.framing_error = ferr_q;
   assign bus.busy          = busy;

endmodule

// File: tb/tb_mfp_uart_rx_16x.sv
// Directed bench for the 16x UART receiver at 50 MHz / 115200 baud (432 clocks per bit).
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_mfp_uart_rx_16x;
   localparam int BIT_CLKS = 432;

   logic clock = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   mfp_uart_rx_16x_if u_if();

   mfp_uart_rx_16x #(
      .CLK_HZ      (50_000_000),
      .BAUD        (115200),
      .SYNC_STAGES (2)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (u_if)
   );

   always #10 clock = ~clock;

   // Output monitor, sampled on the falling edge.
   int         ready_cnt = 0, ferr_cnt = 0, overlap_cnt = 0, double_cnt = 0, busy_err_cnt = 0;
   logic [7:0] got_q[$];
   logic       prev_ready = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0;

   always @(negedge clock) begin
      if (u_if.byte_ready === 1'b1) begin
         ready_cnt++;
         got_q.push_back(u_if.byte_data);
         if (u_if.busy !== 1'b0 || prev_busy !== 1'b1) busy_err_cnt++;
      end
      if (u_if.framing_error === 1'b1) ferr_cnt++;
      if (u_if.byte_ready === 1'b1 && u_if.framing_error === 1'b1) overlap_cnt++;
      if ((u_if.byte_ready === 1'b1 && prev_ready === 1'b1) ||
          (u_if.framing_error === 1'b1 && prev_ferr === 1'b1)) double_cnt++;
      prev_ready <= u_if.byte_ready;
      prev_ferr  <= u_if.framing_error;
      prev_busy  <= u_if.busy;
   end

   // Snapshot of outputs taken right after a mid-frame reset.
   logic [7:0] snap_data;
   logic       snap_ready, snap_ferr, snap_busy;

   task automatic drive_level(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         u_if.rx = v;
         @(posedge clock); #1;
      end
   endtask

   // One 8N1 frame; optional 1-clock inversion at glitch_at and 2-clock reset at rst_at.
   task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int bc,
                              input int glitch_at, input int rst_at);
      logic [9:0] bits;
      bits = {stop_bit, d, 1'b0};
      for (int c = 0; c < 10 * bc; c++) begin
         u_if.rx = bits[c / bc] ^ (c == glitch_at);
         if (rst_at >= 0 && c == rst_at) reset_n = 1'b0;
         if (rst_at >= 0 && c == rst_at + 2) begin
            snap_data  = u_if.byte_data;
            snap_ready = u_if.byte_ready;
            snap_ferr  = u_if.framing_error;
            snap_busy  = u_if.busy;
            reset_n    = 1'b1;
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      u_if.rx = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      n_checks++; if (u_if.byte_data !== 8'h00) begin n_fail++; $display("FAIL reset_byte_data: got %h want 00", u_if.byte_data); end
      n_checks++; if (u_if.byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b want 0", u_if.byte_ready); end
      n_checks++; if (u_if.framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_framing_error: got %b want 0", u_if.framing_error); end
      n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
      reset_n = 1'b1;
      drive_level(1'b1, 20);
   endtask

   task automatic test_single_frame();
      int r0, f0, b0;
      r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_err_cnt;
      got_q.delete();
      drive_frame(8'h53, 1'b1, BIT_CLKS, -1, -1);
      drive_level(1'b1, 50);
      n_checks++; if (ready_cnt - r0 != 1) begin n_fail++; $display("FAIL single_ready_count: got %0d want 1", ready_cnt - r0); end
      n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h53) begin n_fail++; $display("FAIL single_pulse_data: got %h want 53", got_q[0]); end
      n_checks++; if (u_if.byte_data !== 8'h53) begin n_fail++; $display("FAIL single_byte_data_held: got %h want 53", u_if.byte_data); end
      n_checks++; if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
      n_checks++; if (busy_err_cnt - b0 != 0) begin n_fail++; $display("FAIL single_busy_fall: got %0d bad edges want 0", busy_err_cnt - b0); end
      n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", u_if.busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [3];
      int r0, f0;
      exp[0] = 8'h53; exp[1] = 8'h31; exp[2] = 8'h0A;
      r0 = ready_cnt; f0 = ferr_cnt;
      got_q.delete();
      for (int i = 0; i < 3; i++) drive_frame(exp[i], 1'b1, BIT_CLKS, -1, -1);
      drive_level(1'b1, 50);
      n_checks++; if (ready_cnt - r0 != 3) begin n_fail++; $display("FAIL b2b_ready_count: got %0d want 3", ready_cnt - r0); end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (got_q.size() <= i || got_q[i] !== exp[i]) begin
            n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp[i]);
         end
      end
      n_checks++; if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0); end
   endtask

   task automatic test_glitch();
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      drive_level(1'b0, 150);
      n_checks++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start_seen: busy got %b want 1", u_if.busy); end
      drive_level(1'b1, 100);
      n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_back_idle: busy got %b want 0", u_if.busy); end
      n_checks++; if (ready_cnt - r0 != 0 || ferr_cnt - f0 != 0) begin
         n_fail++; $display("FAIL glitch_no_output: ready %0d ferr %0d want 0 0", ready_cnt - r0, ferr_cnt - f0);
      end
      got_q.delete();
      // High spike exactly on the tick-8 vote of data bit 3.
      drive_frame(8'h00, 1'b1, BIT_CLKS, 27 * (16 * 4 + 8), -1);
      drive_level(1'b1, 50);
      n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h00) begin n_fail++; $display("FAIL glitch_vote_data: got %h (n=%0d) want 00", got_q[0], got_q.size()); end
      n_checks++; if (u_if.byte_data !== 8'h00) begin n_fail++; $display("FAIL glitch_byte_data: got %h want 00", u_if.byte_data); end
   endtask

   task automatic test_framing_error();
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      drive_frame(8'hA5, 1'b0, BIT_CLKS, -1, -1);
      drive_level(1'b0, 5 * BIT_CLKS);
      drive_level(1'b1, 100);
      n_checks++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
      n_checks++; if (ready_cnt - r0 != 0) begin n_fail++; $display("FAIL ferr_no_ready: got %0d want 0", ready_cnt - r0); end
      n_checks++; if (u_if.byte_data !== 8'h00) begin n_fail++; $display("FAIL ferr_data_kept: got %h want 00", u_if.byte_data); end
      drive_frame(8'h3C, 1'b1, BIT_CLKS, -1, -1);
      drive_level(1'b1, 50);
      n_checks++; if (ready_cnt - r0 != 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d want 1", ready_cnt - r0); end
      n_checks++; if (u_if.byte_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_recover_data: got %h want 3c", u_if.byte_data); end
      n_checks++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_total: got %0d want 1", ferr_cnt - f0); end
   endtask

   task automatic test_reset_mid_frame();
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      drive_frame(8'hFF, 1'b1, BIT_CLKS, -1, 5 * BIT_CLKS + 100);
      n_checks++; if (snap_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_byte_data: got %h want 00", snap_data); end
      n_checks++; if (snap_ready !== 1'b0 || snap_ferr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulses: got %b%b want 00", snap_ready, snap_ferr); end
      n_checks++; if (snap_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", snap_busy); end
      n_checks++; if (ready_cnt - r0 != 0 || ferr_cnt - f0 != 0) begin
         n_fail++; $display("FAIL rst_mid_discard: ready %0d ferr %0d want 0 0", ready_cnt - r0, ferr_cnt - f0);
      end
      drive_frame(8'h12, 1'b1, BIT_CLKS, -1, -1);
      drive_level(1'b1, 50);
      n_checks++; if (ready_cnt - r0 != 1 || u_if.byte_data !== 8'h12) begin
         n_fail++; $display("FAIL rst_mid_next_frame: count %0d data %h want 1 12", ready_cnt - r0, u_if.byte_data);
      end
   endtask

   task automatic test_baud_tolerance();
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      got_q.delete();
      for (int i = 0; i < 2; i++) drive_frame(8'h55, 1'b1, 421, -1, -1);
      drive_level(1'b1, 100);
      for (int i = 0; i < 2; i++) drive_frame(8'h55, 1'b1, 443, -1, -1);
      drive_level(1'b1, 50);
      n_checks++; if (ready_cnt - r0 != 4) begin n_fail++; $display("FAIL baud_ready_count: got %0d want 4", ready_cnt - r0); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got_q.size() <= i || got_q[i] !== 8'h55) begin
            n_fail++; $display("FAIL baud_data[%0d]: got %h want 55", i, got_q[i]);
         end
      end
      n_checks++; if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL baud_ferr: got %0d want 0", ferr_cnt - f0); end
   endtask

   task automatic test_pulse_rules();
      n_checks++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL pulse_overlap: got %0d want 0", overlap_cnt); end
      n_checks++; if (double_cnt != 0) begin n_fail++; $display("FAIL pulse_two_cycles: got %0d want 0", double_cnt); end
   endtask

   initial begin
      #1_900_000;
      $display("FAIL watchdog: cycle budget of 95000 clocks exceeded, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      u_if.rx = 1'b1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_glitch();
      test_framing_error();
      test_reset_mid_frame();
      test_baud_tolerance();
      test_pulse_rules();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
